hwce_tcdm_lane_adapt: RTL
=========================

HWCE_TCDM_LANE_ADAPT -- requirements
Module: hwce_tcdm_lane_adapt

Interface
REQ-001 SHALL have parameter NPX, default 4: number of TCDM lanes (1..8).
REQ-002 SHALL have parameter DW, default 16: lane data width (16 or 32); BE_W = DW/8 is derived.
REQ-003 SHALL have parameter AW, default 32: address width.
REQ-004 SHALL have the following ports (name, direction, width, meaning):
- clk_i  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous abort.
- req_valid_i  in  1  engine request valid.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- req_type_i  in  1  1=write, 0=read.
- req_add_i  in  AW  base byte address.
- req_mask_i  in  NPX  active lanes.
- req_be_i  in  NPX*BE_W  byte enables.
- req_data_i  in  NPX*DW  write data.
- resp_valid_o  out  1  read data valid.
- resp_ready_i  in  1  engine accepts response.
- resp_data_o  out  NPX*DW  reassembled read data.
- tcdm_req_o  out  NPX  per-lane request.
- tcdm_gnt_i  in  NPX  per-lane grant.
- tcdm_add_o  out  NPX*AW  per-lane address.
- tcdm_wen_o  out  NPX  1=read, 0=write.
- tcdm_be_o  out  NPX*BE_W  per-lane byte enables.
- tcdm_wdata_o  out  NPX*DW  per-lane write data.
- tcdm_r_rdata_i  in  NPX*DW  per-lane read data.
- tcdm_r_valid_i  in  NPX  per-lane read valid.
- stall_cnt_o  out  32  grant-stall cycle counter.
- busy_o  out  1  state != IDLE.

Function
REQ-005 FSM states SHALL be IDLE, ISSUE, COLLECT, RESP.
REQ-006 req_ready_o SHALL be high only in IDLE.
REQ-007 On accept, SHALL register type, address, be, data and mask, set pending[j] = req_mask_i[j], and go to ISSUE.
REQ-008 Lane j address SHALL be req_add_i + j*BE_W, computed modulo 2^AW.
REQ-009 In ISSUE, tcdm_req_o[j] SHALL equal pending[j]; address/wen/be/wdata SHALL be held stable while pending[j]=1.
REQ-010 tcdm_req_o[j] SHALL never be withdrawn before tcdm_gnt_i[j], except on clear_i or reset.
REQ-011 tcdm_gnt_i[j] with pending[j] SHALL clear pending[j] at the next edge; lanes are granted independently, in any order.
REQ-012 When all pending bits are clear, a write SHALL return to IDLE and a read SHALL go to COLLECT.
REQ-013 Read lanes: tcdm_r_valid_i[j] arrives exactly one cycle after that lane's grant and SHALL be captured into collector[j] with done[j] set, including during ISSUE.
REQ-014 r_valid on a lane with no outstanding read SHALL be ignored.
REQ-015 When done == mask, SHALL go to RESP.
REQ-016 In RESP, resp_valid_o=1 and resp_data_o SHALL show collected lanes, with zero on masked-off lanes; data SHALL be held until resp_ready_i, then return to IDLE.
REQ-017 Mask all-zero: a write SHALL return to IDLE in 1 cycle; a read SHALL go to RESP with zero data.
REQ-018 Latency: accept at edge t0, tcdm_req_o high in cycle t1; with zero-wait grant, r_valid in t2 and resp_valid_o high in t3.
REQ-019 stall_cnt_o SHALL increment every cycle in which any tcdm_req_o[j]=1 and tcdm_gnt_i[j]=0, saturating at 2^32-1; clear_i SHALL zero it.
REQ-020 clear_i SHALL have priority over all events: return to IDLE, clear pending and done, drop the response; req_ready_o SHALL return high the next cycle.

Reset
REQ-021 rst_n low SHALL asynchronously force IDLE, pending=0, done=0, collectors=0, stall_cnt=0.
REQ-022 During and after reset: req_ready_o=1, resp_valid_o=0, tcdm_req_o=0, busy_o=0, all data and address outputs 0.
REQ-023 Reset mid-transaction SHALL discard it; late r_valid after reset SHALL be ignored.

Structure
REQ-024 Package hwce_tcdm_pkg SHALL hold the state enum and the lane-address function.
REQ-025 One sub-module, hwce_tcdm_lane, SHALL hold the per-lane pending/done/collector slice, instantiated NPX times by generate.

Verification
REQ-026 NPX=4, DW=16: read at 0x1000, mask 4'b1111, all grants immediate -> addresses 0x1000/0x1002/0x1004/0x1006, resp_valid in t3 with returned data.
REQ-027 Read, lane 2 gnt delayed 3 cycles -> stall_cnt_o=3, resp only after lane 2 r_valid, other lanes' data retained.
REQ-028 Write, mask 4'b0101 -> only lanes 0 and 2 request, wen=0, be/wdata forwarded, no resp_valid_o, back to IDLE.
REQ-029 resp_ready_i held low 5 cycles -> resp_valid_o and data stable, req_ready_o low throughout.
REQ-030 clear_i asserted in ISSUE with lane 1 ungranted -> tcdm_req_o=0 next cycle, stray r_valid ignored, stall_cnt_o=0.
REQ-031 rst_n pulse mid-COLLECT -> all outputs at reset values, a following read completes normally.

Source files
------------

// File: rtl/hwce_tcdm_pkg.sv
// Shared definitions for the HWCE TCDM lane adapter.
//   state_t   : adapter FSM states.
//   lane_addr : byte address of lane 'lane' given a base address and the
//               per-lane byte stride. The caller truncates the result to its
//               own address width, which gives modulo-2^AW wrap.
package hwce_tcdm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    COLLECT = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam int MAX_AW = 64;

  function automatic logic [MAX_AW-1:0] lane_addr(input logic [MAX_AW-1:0] base,
                                                  input int unsigned        lane,
                                                  input int unsigned        be_w);
    return base + MAX_AW'(lane * be_w);
  endfunction

endpackage

// File: rtl/hwce_tcdm_lane.sv
// One TCDM lane slice: tracks whether the lane still has to be granted
// (pending), whether its read data has come back (done), and holds the
// returned read data (collector).
// Ports:
//   clk_i, rst_n  : clock, asynchronous active-low reset
//   clear         : synchronous abort, wins over everything else
//   accept        : a new engine request is being accepted this cycle
//   mask_bit      : this lane takes part in the accepted request
//   is_read       : the transaction in flight is a read
//   gnt           : TCDM grant for this lane
//   r_valid/r_data: TCDM read response for this lane
//   pending, done : lane status
//   captured      : a valid read response is being taken this cycle
//   collector     : last captured read data
module hwce_tcdm_lane #(
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          accept,
  input  logic          mask_bit,
  input  logic          is_read,
  input  logic          gnt,
  input  logic          r_valid,
  input  logic [DW-1:0] r_data,
  output logic          pending,
  output logic          done,
  output logic          captured,
  output logic [DW-1:0] collector
);

  // Set for exactly the cycle after a read grant, which is when the
  // response is due; any r_valid outside that window is dropped.
  logic outstanding;

  assign captured = outstanding & r_valid;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= 1'b0;
      done        <= 1'b0;
      outstanding <= 1'b0;
      collector   <= '0;
    end else if (clear) begin
      pending     <= 1'b0;
      done        <= 1'b0;
      outstanding <= 1'b0;
    end else begin
      outstanding <= pending & gnt & is_read;
      if (accept) begin
        pending <= mask_bit;
        done    <= 1'b0;
      end else begin
        if (pending && gnt) pending <= 1'b0;
        if (captured) begin
          done      <= 1'b1;
          collector <= r_data;
        end
      end
    end
  end

endmodule

// File: rtl/hwce_tcdm_lane_adapt.sv
// Splits one wide engine request into NPX independent TCDM lane requests
// and reassembles the per-lane read responses into a single wide response.
// Ports:
//   clk_i, rst_n, clear_i           : clock, async active-low reset, sync abort
//   req_*                           : engine request (valid/ready handshake)
//   resp_*                          : engine read response (valid/ready handshake)
//   tcdm_*                          : NPX TCDM lanes (req/gnt, then r_valid one cycle later)
//   stall_cnt_o                     : saturating count of cycles with an ungranted request
//   busy_o                          : a transaction is in progress
module hwce_tcdm_lane_adapt
  import hwce_tcdm_pkg::*;
#(
  parameter int NPX = 4,
  parameter int DW  = 16,
  parameter int AW  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic                    clear_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_type_i,
  input  logic [AW-1:0]           req_add_i,
  input  logic [NPX-1:0]          req_mask_i,
  input  logic [NPX*(DW/8)-1:0]   req_be_i,
  input  logic [NPX*DW-1:0]       req_data_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [NPX*DW-1:0]       resp_data_o,
  output logic [NPX-1:0]          tcdm_req_o,
  input  logic [NPX-1:0]          tcdm_gnt_i,
  output logic [NPX*AW-1:0]       tcdm_add_o,
  output logic [NPX-1:0]          tcdm_wen_o,
  output logic [NPX*(DW/8)-1:0]   tcdm_be_o,
  output logic [NPX*DW-1:0]       tcdm_wdata_o,
  input  logic [NPX*DW-1:0]       tcdm_r_rdata_i,
  input  logic [NPX-1:0]          tcdm_r_valid_i,
  output logic [31:0]             stall_cnt_o,
  output logic                    busy_o
);

  localparam int BE_W = DW / 8;

  state_t                  state;
  logic                    is_read;
  logic [AW-1:0]           base_addr;
  logic [NPX*BE_W-1:0]     be_q;
  logic [NPX*DW-1:0]       wdata_q;
  logic [NPX-1:0]          mask_q;
  logic [NPX-1:0]          pending;
  logic [NPX-1:0]          done;
  logic [NPX-1:0]          captured;
  logic [NPX-1:0]          pending_nxt;
  logic [NPX-1:0]          done_nxt;
  logic [NPX*DW-1:0]       collect;
  logic [31:0]             stall_cnt;
  logic                    accept;

  // Holding ready low during clear keeps an abort from racing a new accept.
  assign req_ready_o  = (state == IDLE) && !clear_i;
  assign accept       = req_valid_i && req_ready_o;
  assign busy_o       = (state != IDLE);
  assign resp_valid_o = (state == RESP);
  assign tcdm_req_o   = pending;
  assign stall_cnt_o  = stall_cnt;

  // Look-ahead status lets the FSM move on the same edge the last grant or
  // response lands, which keeps the read latency at three cycles.
  assign pending_nxt = pending & ~tcdm_gnt_i;
  assign done_nxt    = done | captured;

  for (genvar gi = 0; gi < NPX; gi++) begin : g_lane
    hwce_tcdm_lane #(.DW(DW)) u_lane (
      .clk_i     (clk_i),
      .rst_n     (rst_n),
      .clear     (clear_i),
      .accept    (accept),
      .mask_bit  (req_mask_i[gi]),
      .is_read   (is_read),
      .gnt       (tcdm_gnt_i[gi]),
      .r_valid   (tcdm_r_valid_i[gi]),
      .r_data    (tcdm_r_rdata_i[gi*DW +: DW]),
      .pending   (pending[gi]),
      .done      (done[gi]),
      .captured  (captured[gi]),
      .collector (collect[gi*DW +: DW])
    );

    // Lane-side outputs are only driven while the lane is requesting, so
    // idle lanes and the reset state show all zeros.
    assign tcdm_add_o[gi*AW +: AW] =
      pending[gi] ? AW'(lane_addr(MAX_AW'(base_addr), gi, BE_W)) : '0;
    assign tcdm_wen_o[gi]              = pending[gi] & is_read;
    assign tcdm_be_o[gi*BE_W +: BE_W]  = be_q[gi*BE_W +: BE_W] & {BE_W{pending[gi]}};
    assign tcdm_wdata_o[gi*DW +: DW]   = wdata_q[gi*DW +: DW] & {DW{pending[gi]}};
    assign resp_data_o[gi*DW +: DW]    =
      collect[gi*DW +: DW] & {DW{(state == RESP) && mask_q[gi]}};
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      is_read   <= 1'b0;
      base_addr <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
    end else if (clear_i) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            is_read   <= !req_type_i;
            base_addr <= req_add_i;
            be_q      <= req_be_i;
            wdata_q   <= req_data_i;
            mask_q    <= req_mask_i;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (pending_nxt == '0) begin
            if (!is_read)                state <= IDLE;
            else if (done_nxt == mask_q) state <= RESP;
            else                         state <= COLLECT;
          end
        end
        COLLECT: begin
          if (done_nxt == mask_q) state <= RESP;
        end
        RESP: begin
          if (resp_ready_i) state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clear_i) begin
      stall_cnt <= '0;
    end else if (|(pending & ~tcdm_gnt_i) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule
